// File: rtl/ncc_pkg.sv
// ncc_pkg: score type, most-negative constant and peak-finder states shared by the NCC stages
package ncc_pkg;
    localparam int SCORE_W = 32;
    typedef logic signed [SCORE_W-1:0] score_t;
    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, SCAN, DONE} peak_state_t;
endpackage

// File: rtl/ncc_peak_finder_raster_counter.sv
// raster_counter: x/y raster position counter with clear, enable, wrap and last-position flag
module raster_counter #(
    parameter int NUM_X = 65,
    parameter int NUM_Y = 1,
    localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1,
    localparam int YW = (NUM_Y > 1) ? $clog2(NUM_Y) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    localparam logic [XW-1:0] X_MAX = XW'(NUM_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(NUM_Y - 1);
    assign last = (x == X_MAX) && (y == Y_MAX);
    // advance in raster order; y wraps explicitly so non-power-of-two heights work
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            x <= (x == X_MAX) ? '0 : x + 1'b1;
            if (x == X_MAX) y <= last ? '0 : y + 1'b1;
        end
    end
endmodule

// File: rtl/ncc_peak_finder.sv
// ncc_peak_finder: tracks the best NCC score and its offset per search; NCC_SECOND_PEAK_EN adds runner-up tracking
module ncc_peak_finder
    import ncc_pkg::*;
#(
    parameter int NUM_X = 65,
    parameter int NUM_Y = 1,
    localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1,
    localparam int YW = (NUM_Y > 1) ? $clog2(NUM_Y) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score,
    output logic                      busy,
    output logic                      peak_valid,
    output logic signed [SCORE_W-1:0] peak_score,
    output logic        [XW-1:0]      peak_x,
    output logic        [YW-1:0]      peak_y,
    output logic signed [SCORE_W-1:0] second_score
);
    peak_state_t   state, next_state;
    score_t        best;
    logic [XW-1:0] x, best_x;
    logic [YW-1:0] y, best_y;
    logic          last, xfer, begin_scan;

    assign begin_scan = (state == IDLE) && start;
    assign xfer       = score_valid && score_ready;

    raster_counter #(.NUM_X(NUM_X), .NUM_Y(NUM_Y)) u_cnt (
        .clk(clk), .rst(rst), .clear(begin_scan), .en(xfer), .x(x), .y(y), .last(last)
    );

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : next_state;

    // next state: start only matters in IDLE, the final raster transfer ends the scan
    always_comb begin
        next_state = (state == IDLE) ? (start ? SCAN : IDLE) :
                     (state == SCAN) ? ((xfer && last) ? DONE : SCAN) : IDLE;
    end

    // handshake and status outputs
    always_comb begin
        score_ready = (state == SCAN);
        busy        = (state != IDLE);
    end

    // running best; strict compare keeps the earliest position on ties
    always_ff @(posedge clk) begin
        if (rst || begin_scan) begin
            best   <= SCORE_MIN;
            best_x <= '0;
            best_y <= '0;
        end else if (xfer && score > best) begin
            best   <= score;
            best_x <= x;
            best_y <= y;
        end
    end

    // publish the result in DONE and hold it until the next search completes
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_valid <= 1'b0;
            peak_score <= SCORE_MIN;
            peak_x     <= '0;
            peak_y     <= '0;
        end else begin
            peak_valid <= (state == DONE);
            if (state == DONE) begin
                peak_score <= best;
                peak_x     <= best_x;
                peak_y     <= best_y;
            end
        end
    end

`ifdef NCC_SECOND_PEAK_EN
    score_t second;
    // runner-up: a displaced best drops to second, otherwise a strictly larger score replaces it
    always_ff @(posedge clk) begin
        if (rst || begin_scan) second <= SCORE_MIN;
        else if (xfer) second <= (score > best) ? best : (score > second) ? score : second;
    end
    // publish the runner-up alongside the peak
    always_ff @(posedge clk) begin
        if (rst) second_score <= SCORE_MIN;
        else if (state == DONE) second_score <= second;
    end
`else
    assign second_score = SCORE_MIN;
`endif
endmodule

// File: tb/tb_ncc_peak_finder.sv
// tb_ncc_peak_finder: directed checks of the peak finder on a 65x1 and a 4x3 search window
module tb_ncc_peak_finder;
    import ncc_pkg::*;
`ifdef NCC_SECOND_PEAK_EN
    localparam bit SP = 1'b1;
`else
    localparam bit SP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic start0 = 1'b0, sv0 = 1'b0, rdy0, busy0, pv0;
    logic start1 = 1'b0, sv1 = 1'b0, rdy1, busy1, pv1;
    logic signed [31:0] sc0 = '0, sc1 = '0, ps0, ps1, ss0, ss1;
    logic [6:0] px0;
    logic [0:0] py0;
    logic [1:0] px1, py1;
    int n_chk = 0, n_pass = 0;
    int pv_n0 = 0, pv_n1 = 0, xf_n0 = 0;
    int pv_snap, xf_snap;

    always #5 clk = ~clk;

    ncc_peak_finder #(.NUM_X(65), .NUM_Y(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .score_valid(sv0), .score_ready(rdy0), .score(sc0),
        .busy(busy0), .peak_valid(pv0), .peak_score(ps0), .peak_x(px0), .peak_y(py0), .second_score(ss0)
    );
    ncc_peak_finder #(.NUM_X(4), .NUM_Y(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .score_valid(sv1), .score_ready(rdy1), .score(sc1),
        .busy(busy1), .peak_valid(pv1), .peak_score(ps1), .peak_x(px1), .peak_y(py1), .second_score(ss1)
    );

    always @(posedge clk) begin
        pv_n0 <= pv_n0 + int'(pv0);
        pv_n1 <= pv_n1 + int'(pv1);
        xf_n0 <= xf_n0 + int'(sv0 && rdy0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic push(input bit sel, input logic [31:0] v, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        if (sel) begin sv1 = 1'b1; sc1 = v; end else begin sv0 = 1'b1; sc0 = v; end
        while (!(sel ? rdy1 : rdy0) && t < 50) begin @(negedge clk); t++; end
        if (t == 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (sel) sv1 = 1'b0; else sv0 = 1'b0;
    endtask

    task automatic check_pulse(input bit sel, input string tag);
        check({tag, "_pv_early"}, 32'(sel ? pv1 : pv0), 32'd0);
        @(negedge clk);
        check({tag, "_pv"}, 32'(sel ? pv1 : pv0), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_pv", 32'(pv0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_score", ps0, 32'h8000_0000);
        check("rst_x", 32'(px0), 32'd0);
        check("rst_second", ss0, 32'h8000_0000);

        pv_snap = pv_n0;
        pulse_start(1'b0);
        check("t2_ready", 32'(rdy0), 32'd1);
        check("t2_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 65; i++) push(1'b0, (i == 0 || i == 40) ? 32'd100 : 32'd0, 0);
        check("t2_busy_done", 32'(busy0), 32'd1);
        check_pulse(1'b0, "t2");
        check("t2_score", ps0, 32'd100);
        check("t2_x", 32'(px0), 32'd0);
        check("t2_y", 32'(py0), 32'd0);
        check("t2_second", ss0, SP ? 32'd100 : 32'h8000_0000);
        check("t2_busy_idle", 32'(busy0), 32'd0);
        @(negedge clk);
        check("t2_pv_one_cycle", 32'(pv_n0 - pv_snap), 32'd1);

        xf_snap = xf_n0;
        pulse_start(1'b0);
        for (int i = 0; i < 65; i++) begin
            if (i == 10 || i == 50) start0 = 1'b1;
            push(1'b0, 32'(-5 - i), $urandom_range(0, 3));
            start0 = 1'b0;
        end
        check("t3_ready_done", 32'(rdy0), 32'd0);
        check_pulse(1'b0, "t3");
        check("t3_score", ps0, 32'hFFFF_FFFB);
        check("t3_x", 32'(px0), 32'd0);
        check("t3_second", ss0, SP ? 32'hFFFF_FFFA : 32'h8000_0000);
        repeat (3) @(negedge clk);
        check("t3_xfers", 32'(xf_n0 - xf_snap), 32'd65);
        check("t3_idle_ready", 32'(rdy0), 32'd0);

        pulse_start(1'b1);
        for (int i = 0; i < 12; i++) begin
            push(1'b1, (i == 9) ? 32'd7 : 32'(i % 4), 0);
            if (i == 10) check("t4_ready_11", 32'(rdy1), 32'd1);
        end
        check("t4_ready_12", 32'(rdy1), 32'd0);
        check_pulse(1'b1, "t4");
        check("t4_score", ps1, 32'd7);
        check("t4_x", 32'(px1), 32'd1);
        check("t4_y", 32'(py1), 32'd2);
        check("t4_second", ss1, SP ? 32'd3 : 32'h8000_0000);

        pv_snap = pv_n0;
        pulse_start(1'b0);
        for (int i = 0; i < 30; i++) push(1'b0, (i == 5) ? 32'd1000 : 32'd1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_ready", 32'(rdy0), 32'd0);
        check("t5_rst_score", ps0, 32'h8000_0000);
        repeat (4) @(negedge clk);
        check("t5_no_pv", 32'(pv_n0 - pv_snap), 32'd0);
        pulse_start(1'b0);
        for (int i = 0; i < 65; i++) push(1'b0, (i == 64) ? 32'd50 : 32'(i % 20), 0);
        check_pulse(1'b0, "t5");
        check("t5_score", ps0, 32'd50);
        check("t5_x", 32'(px0), 32'd64);
        check("t5_second", ss0, SP ? 32'd19 : 32'h8000_0000);
        @(negedge clk);
        check("t5_pv_count", 32'(pv_n0 - pv_snap), 32'd1);

        pulse_start(1'b1);
        for (int i = 0; i < 12; i++)
            push(1'b1, (i == 0) ? 32'd10 : (i == 1) ? 32'd30 : (i == 2) ? 32'd20 : (i == 3) ? 32'd25 : 32'hFFFF_FF9C, 1);
        check_pulse(1'b1, "t6");
        check("t6_score", ps1, 32'd30);
        check("t6_x", 32'(px1), 32'd1);
        check("t6_y", 32'(py1), 32'd0);
        check("t6_second", ss1, SP ? 32'd25 : 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
